parallel_mul_twiddle_fft4: RTL and testbench



---
 rtl/parallel_mul_twiddle_fft4_pkg.sv | 60 ++++++
 rtl/parallel_mul_twiddle_fft4_twiddle_rom.sv | 69 ++++++
 rtl/parallel_mul_twiddle_fft4.sv | 159 +++++++++++++++
 tb/tb_parallel_mul_twiddle_fft4.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parallel_mul_twiddle_fft4_pkg.sv
// Shared constants, complex payload types and twiddle quantisation for the
// final radix-4 stage of the 8192-point FFT.
package parallel_mul_twiddle_fft4_pkg;

  localparam int unsigned DATA_WIDTH  = 21;
  localparam int unsigned TWID_WIDTH  = 16;
  localparam int unsigned MSB_CUTOFF  = 26;
  localparam int unsigned LSB_CUTOFF  = 12;
  localparam int unsigned SHIFT       = 15;
  localparam int unsigned OUT_WIDTH   = MSB_CUTOFF + 1;
  localparam int unsigned PROD_WIDTH  = DATA_WIDTH + TWID_WIDTH;
  localparam int unsigned FULL_WIDTH  = PROD_WIDTH + 1;

  localparam int unsigned FFT_N       = 8192;
  localparam int unsigned GROUPS      = 2048;
  localparam int unsigned LABLE_WIDTH = 11;
  localparam int unsigned N_WIDTH     = 13;
  localparam int unsigned QUARTER     = FFT_N / 4;
  localparam int unsigned ADDR_WIDTH  = 12;
  localparam int unsigned LANES       = 4;

  localparam int  TWID_MAX = (1 << SHIFT) - 1;
  localparam real PI       = 3.14159265358979323846;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] r;
    logic signed [DATA_WIDTH-1:0] i;
  } cplx_in_t;

  typedef struct packed {
    logic signed [TWID_WIDTH-1:0] r;
    logic signed [TWID_WIDTH-1:0] i;
  } cplx_tw_t;

  typedef struct packed {
    logic signed [OUT_WIDTH-1:0] r;
    logic signed [OUT_WIDTH-1:0] i;
  } cplx_out_t;

  // Four partial products of one complex multiply, before the add/sub.
  typedef struct packed {
    logic signed [PROD_WIDTH-1:0] rr;
    logic signed [PROD_WIDTH-1:0] ii;
    logic signed [PROD_WIDTH-1:0] ri;
    logic signed [PROD_WIDTH-1:0] ir;
  } cplx_prod_t;

  // Round half away from zero at 2^SHIFT, saturate symmetrically to +/-TWID_MAX.
  function automatic logic signed [TWID_WIDTH-1:0] twiddle_quant(input real v);
    real s;
    int  q;
    s = v * real'(1 << SHIFT);
    if (s >= 0.0) q = $rtoi(s + 0.5);
    else          q = -$rtoi(-s + 0.5);
    if (q > TWID_MAX)  q = TWID_MAX;
    if (q < -TWID_MAX) q = -TWID_MAX;
    return TWID_WIDTH'(q);
  endfunction

endpackage

// File: rtl/parallel_mul_twiddle_fft4_twiddle_rom.sv
// Quarter-wave cosine table with quadrant folding; three registered read
// ports return W(m), W(2m), W(3m) for group index m.
module parallel_mul_twiddle_fft4_twiddle_rom
  import parallel_mul_twiddle_fft4_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LABLE_WIDTH-1:0] lable,
  output cplx_tw_t               tw1,
  output cplx_tw_t               tw2,
  output cplx_tw_t               tw3
);

  localparam int unsigned QBITS = N_WIDTH - 2;

  logic signed [TWID_WIDTH-1:0] cos_tbl [0:QUARTER];
  logic [N_WIDTH-1:0]           n_sel [3];
  logic [ADDR_WIDTH-1:0]        ofs_a;
  logic [ADDR_WIDTH-1:0]        ofs_b;
  cplx_tw_t                     tw_c [3];

  // cos(2*pi*a/N) for a = 0..N/4; sin is read from the mirrored address.
  for (genvar a = 0; a <= QUARTER; a++) begin : g_tbl
    assign cos_tbl[a] = twiddle_quant($cos(2.0 * PI * real'(a) / real'(FFT_N)));
  end

  // W = cos - j*sin, with ca = cos(phi) and cb = sin(phi) inside the quadrant.
  function automatic cplx_tw_t map_quadrant(input logic [1:0] quad,
                                            input logic signed [TWID_WIDTH-1:0] ca,
                                            input logic signed [TWID_WIDTH-1:0] cb);
    cplx_tw_t w;
    case (quad)
      2'd0: begin w.r = ca;  w.i = -cb; end
      2'd1: begin w.r = -cb; w.i = -ca; end
      2'd2: begin w.r = -ca; w.i = cb;  end
      default: begin w.r = cb; w.i = ca; end
    endcase
    return w;
  endfunction

  always_comb begin
    n_sel[0] = N_WIDTH'(lable);
    n_sel[1] = N_WIDTH'({lable, 1'b0});
    n_sel[2] = n_sel[0] + n_sel[1];
  end

  always_comb begin
    ofs_a = '0;
    ofs_b = '0;
    for (int p = 0; p < 3; p++) begin
      ofs_a   = {1'b0, n_sel[p][QBITS-1:0]};
      ofs_b   = ADDR_WIDTH'(QUARTER) - ofs_a;
      tw_c[p] = map_quadrant(n_sel[p][N_WIDTH-1 -: 2], cos_tbl[ofs_a], cos_tbl[ofs_b]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tw1 <= '0;
      tw2 <= '0;
      tw3 <= '0;
    end else begin
      tw1 <= tw_c[0];
      tw2 <= tw_c[1];
      tw3 <= tw_c[2];
    end
  end

endmodule

// File: rtl/parallel_mul_twiddle_fft4.sv
// Final radix-4 DIT stage: twiddle multiply, floor truncation and butterfly
// over four lanes per cycle, fixed four-stage pipeline.
module parallel_mul_twiddle_fft4
  import parallel_mul_twiddle_fft4_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid,
  input  logic [LABLE_WIDTH-1:0]        lable,
  input  logic signed [DATA_WIDTH-1:0]  x0_r,
  input  logic signed [DATA_WIDTH-1:0]  x0_i,
  input  logic signed [DATA_WIDTH-1:0]  x1_r,
  input  logic signed [DATA_WIDTH-1:0]  x1_i,
  input  logic signed [DATA_WIDTH-1:0]  x2_r,
  input  logic signed [DATA_WIDTH-1:0]  x2_i,
  input  logic signed [DATA_WIDTH-1:0]  x3_r,
  input  logic signed [DATA_WIDTH-1:0]  x3_i,
  output logic signed [OUT_WIDTH-1:0]   y0_r,
  output logic signed [OUT_WIDTH-1:0]   y0_i,
  output logic signed [OUT_WIDTH-1:0]   y1_r,
  output logic signed [OUT_WIDTH-1:0]   y1_i,
  output logic signed [OUT_WIDTH-1:0]   y2_r,
  output logic signed [OUT_WIDTH-1:0]   y2_i,
  output logic signed [OUT_WIDTH-1:0]   y3_r,
  output logic signed [OUT_WIDTH-1:0]   y3_i,
  output logic [LABLE_WIDTH-1:0]        index,
  output logic                          ready
);

  cplx_in_t                  x_in [LANES];
  cplx_tw_t                  tw   [LANES];
  cplx_tw_t                  rom_tw1, rom_tw2, rom_tw3;

  logic                      s1_valid, s2_valid, s3_valid;
  logic [LABLE_WIDTH-1:0]    s1_lable, s2_lable, s3_lable;
  cplx_in_t                  s1_x [LANES];
  cplx_prod_t                s2_p [LANES];
  cplx_out_t                 s3_t [LANES];
  cplx_out_t                 y    [LANES];

  logic signed [FULL_WIDTH-1:0] p_r [LANES];
  logic signed [FULL_WIDTH-1:0] p_i [LANES];
  cplx_out_t                 t_c  [LANES];
  cplx_out_t                 y_c  [LANES];

  always_comb begin
    x_in[0] = '{r: x0_r, i: x0_i};
    x_in[1] = '{r: x1_r, i: x1_i};
    x_in[2] = '{r: x2_r, i: x2_i};
    x_in[3] = '{r: x3_r, i: x3_i};
  end

  // Addressed straight from the input so twiddles line up with S1 data.
  parallel_mul_twiddle_fft4_twiddle_rom u_rom (
    .clk   (clk),
    .rst   (rst),
    .lable (lable),
    .tw1   (rom_tw1),
    .tw2   (rom_tw2),
    .tw3   (rom_tw3)
  );

  always_comb begin
    tw[0].r = TWID_WIDTH'(TWID_MAX);
    tw[0].i = '0;
    tw[1]   = rom_tw1;
    tw[2]   = rom_tw2;
    tw[3]   = rom_tw3;
  end

  // S1: input capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lable <= '0;
      for (int k = 0; k < LANES; k++) s1_x[k] <= '0;
    end else begin
      s1_valid <= valid;
      s1_lable <= lable;
      for (int k = 0; k < LANES; k++) s1_x[k] <= x_in[k];
    end
  end

  // S2: full-precision partial products.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_lable <= '0;
      for (int k = 0; k < LANES; k++) s2_p[k] <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_lable <= s1_lable;
      for (int k = 0; k < LANES; k++) begin
        s2_p[k].rr <= PROD_WIDTH'(s1_x[k].r) * PROD_WIDTH'(tw[k].r);
        s2_p[k].ii <= PROD_WIDTH'(s1_x[k].i) * PROD_WIDTH'(tw[k].i);
        s2_p[k].ri <= PROD_WIDTH'(s1_x[k].r) * PROD_WIDTH'(tw[k].i);
        s2_p[k].ir <= PROD_WIDTH'(s1_x[k].i) * PROD_WIDTH'(tw[k].r);
      end
    end
  end

  // Complex add then floor-shift; the result always fits in OUT_WIDTH.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      p_r[k]   = FULL_WIDTH'(s2_p[k].rr) - FULL_WIDTH'(s2_p[k].ii);
      p_i[k]   = FULL_WIDTH'(s2_p[k].ri) + FULL_WIDTH'(s2_p[k].ir);
      t_c[k].r = OUT_WIDTH'(p_r[k] >>> LSB_CUTOFF);
      t_c[k].i = OUT_WIDTH'(p_i[k] >>> LSB_CUTOFF);
    end
  end

  // S3: truncated twiddled samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_lable <= '0;
      for (int k = 0; k < LANES; k++) s3_t[k] <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_lable <= s2_lable;
      for (int k = 0; k < LANES; k++) s3_t[k] <= t_c[k];
    end
  end

  // Radix-4 butterfly; -j*(a + jb) = b - ja. Wraps at OUT_WIDTH.
  always_comb begin
    y_c[0].r = s3_t[0].r + s3_t[1].r + s3_t[2].r + s3_t[3].r;
    y_c[0].i = s3_t[0].i + s3_t[1].i + s3_t[2].i + s3_t[3].i;
    y_c[1].r = s3_t[0].r + s3_t[1].i - s3_t[2].r - s3_t[3].i;
    y_c[1].i = s3_t[0].i - s3_t[1].r - s3_t[2].i + s3_t[3].r;
    y_c[2].r = s3_t[0].r - s3_t[1].r + s3_t[2].r - s3_t[3].r;
    y_c[2].i = s3_t[0].i - s3_t[1].i + s3_t[2].i - s3_t[3].i;
    y_c[3].r = s3_t[0].r - s3_t[1].i - s3_t[2].r + s3_t[3].i;
    y_c[3].i = s3_t[0].i + s3_t[1].r - s3_t[2].i - s3_t[3].r;
  end

  // S4: output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      index <= '0;
      for (int k = 0; k < LANES; k++) y[k] <= '0;
    end else begin
      ready <= s3_valid;
      index <= s3_lable;
      for (int k = 0; k < LANES; k++) y[k] <= y_c[k];
    end
  end

  assign y0_r = y[0].r;
  assign y0_i = y[0].i;
  assign y1_r = y[1].r;
  assign y1_i = y[1].i;
  assign y2_r = y[2].r;
  assign y2_i = y[2].i;
  assign y3_r = y[3].r;
  assign y3_i = y[3].i;

endmodule

// File: tb/tb_parallel_mul_twiddle_fft4.sv
// Randomised bench for parallel_mul_twiddle_fft4 against a DFT-style
// reference model of twiddle, floor truncation and radix-4 combination.
module tb_parallel_mul_twiddle_fft4;

  localparam int  MAXC = 4000;
  localparam real PI   = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid;
  logic [10:0]        lable;
  logic signed [20:0] xr [4];
  logic signed [20:0] xi [4];
  logic signed [26:0] yr [4];
  logic signed [26:0] yi [4];
  logic [10:0]        index;
  logic               ready;

  parallel_mul_twiddle_fft4 dut (
    .clk(clk), .rst(rst), .valid(valid), .lable(lable),
    .x0_r(xr[0]), .x0_i(xi[0]), .x1_r(xr[1]), .x1_i(xi[1]),
    .x2_r(xr[2]), .x2_i(xi[2]), .x3_r(xr[3]), .x3_i(xi[3]),
    .y0_r(yr[0]), .y0_i(yi[0]), .y1_r(yr[1]), .y1_i(yi[1]),
    .y2_r(yr[2]), .y2_i(yi[2]), .y3_r(yr[3]), .y3_i(yi[3]),
    .index(index), .ready(ready)
  );

  initial forever #5 clk = ~clk;

  // Per-cycle record of what was driven, indexed by the cycle stamp.
  bit     st_v   [MAXC];
  bit     st_rst [MAXC];
  int     st_m   [MAXC];
  int     st_xr  [MAXC][4];
  int     st_xi  [MAXC][4];
  bit     st_dir [MAXC];
  longint dir_r  [MAXC][4];
  longint dir_i  [MAXC][4];

  int     nx_r [4];
  int     nx_i [4];
  longint exp_r [4];
  longint exp_i [4];

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint qtw(input real v);
    real    s;
    longint q;
    s = v * 32768.0;
    if (s >= 0.0) q = longint'($rtoi(s + 0.5));
    else          q = -longint'($rtoi(-s + 0.5));
    if (q > 32767)  q = 32767;
    if (q < -32767) q = -32767;
    return q;
  endfunction

  function automatic longint wrap27(input longint v);
    longint m;
    m = v & ((longint'(1) << 27) - 1);
    if (m >= (longint'(1) << 26)) m = m - (longint'(1) << 27);
    return m;
  endfunction

  // y_q = sum_k T_k * (-j)^(k*q), T_k = floor((x_k * W^(k*m)) / 2^12).
  task automatic model(input int c);
    longint tr [4];
    longint ti [4];
    longint wr, wi, pr, pi, sr, si;
    real    ang;
    int     e;
    for (int k = 0; k < 4; k++) begin
      ang   = 2.0 * PI * real'(k * st_m[c]) / 8192.0;
      wr    = qtw($cos(ang));
      wi    = qtw(-$sin(ang));
      pr    = longint'(st_xr[c][k]) * wr - longint'(st_xi[c][k]) * wi;
      pi    = longint'(st_xr[c][k]) * wi + longint'(st_xi[c][k]) * wr;
      tr[k] = pr >>> 12;
      ti[k] = pi >>> 12;
    end
    for (int q = 0; q < 4; q++) begin
      sr = 0;
      si = 0;
      for (int k = 0; k < 4; k++) begin
        e = (k * q) % 4;
        case (e)
          0: begin sr += tr[k];  si += ti[k];  end
          1: begin sr += ti[k];  si -= tr[k];  end
          2: begin sr -= tr[k];  si -= ti[k];  end
          default: begin sr -= ti[k]; si += tr[k]; end
        endcase
      end
      exp_r[q] = wrap27(sr);
      exp_i[q] = wrap27(si);
    end
  endtask

  task automatic apply(input bit r, input bit v, input int m);
    @(posedge clk);
    #2;
    rst   = r;
    valid = v;
    lable = 11'(m);
    st_rst[cyc] = r;
    st_v[cyc]   = v;
    st_m[cyc]   = m;
    for (int k = 0; k < 4; k++) begin
      xr[k] = 21'(nx_r[k]);
      xi[k] = 21'(nx_i[k]);
      st_xr[cyc][k] = nx_r[k];
      st_xi[cyc][k] = nx_i[k];
    end
  endtask

  task automatic expect_dir(input longint r0, input longint i0, input longint r1, input longint i1,
                            input longint r2, input longint i2, input longint r3, input longint i3);
    st_dir[cyc] = 1'b1;
    dir_r[cyc][0] = r0; dir_i[cyc][0] = i0;
    dir_r[cyc][1] = r1; dir_i[cyc][1] = i1;
    dir_r[cyc][2] = r2; dir_i[cyc][2] = i2;
    dir_r[cyc][3] = r3; dir_i[cyc][3] = i3;
  endtask

  task automatic zero_x();
    for (int k = 0; k < 4; k++) begin
      nx_r[k] = 0;
      nx_i[k] = 0;
    end
  endtask

  task automatic rand_x();
    for (int k = 0; k < 4; k++) begin
      nx_r[k] = int'($signed(21'($urandom)));
      nx_i[k] = int'($signed(21'($urandom)));
    end
  endtask

  // Output checker: the output after edge p belongs to the group stamped p-4.
  initial begin
    bit killed;
    bit exp_ready;
    int c;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      c = cyc - 4;
      killed = 1'b0;
      for (int d = 1; d <= 4; d++)
        if (cyc - d >= 0 && st_rst[cyc - d]) killed = 1'b1;
      exp_ready = (c >= 0) && st_v[c] && !killed;
      check("ready", longint'(ready), longint'(exp_ready));
      if (st_rst[cyc - 1]) begin
        check("rst_index", longint'(index), 0);
        for (int q = 0; q < 4; q++) begin
          check("rst_y_r", longint'(yr[q]), 0);
          check("rst_y_i", longint'(yi[q]), 0);
        end
      end else if (exp_ready) begin
        model(c);
        check("index", longint'(index), longint'(st_m[c]));
        for (int q = 0; q < 4; q++) begin
          check("y_r", longint'(yr[q]), exp_r[q]);
          check("y_i", longint'(yi[q]), exp_i[q]);
          if (st_dir[c]) begin
            check("dir_y_r", longint'(yr[q]), dir_r[c][q]);
            check("dir_y_i", longint'(yi[q]), dir_i[c][q]);
          end
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    lable = '0;
    for (int k = 0; k < 4; k++) begin
      xr[k] = '0;
      xi[k] = '0;
    end
    st_rst[0] = 1'b1;
    zero_x();
    apply(1'b1, 1'b0, 0);
    apply(1'b1, 1'b0, 0);
    apply(1'b0, 1'b0, 0);
    apply(1'b0, 1'b0, 0);

    // Hand-worked groups.
    zero_x(); nx_r[0] = 1000;
    apply(1'b0, 1'b1, 0);
    expect_dir(7999, 0, 7999, 0, 7999, 0, 7999, 0);
    zero_x(); nx_r[1] = 1000;
    apply(1'b0, 1'b1, 0);
    expect_dir(7999, 0, 0, -7999, -7999, 0, 0, 7999);
    zero_x(); nx_r[1] = 1000;
    apply(1'b0, 1'b1, 1024);
    expect_dir(5656, -5657, -5657, -5656, -5656, 5657, 5657, 5656);
    zero_x();
    apply(1'b0, 1'b0, 0);
    apply(1'b0, 1'b0, 0);

    // Full back-to-back sweep of every group index.
    for (int m = 0; m < 2048; m++) begin
      rand_x();
      apply(1'b0, 1'b1, m);
    end

    // Random traffic with gaps and two mid-stream resets.
    for (int i = 0; i < 200; i++) begin
      rand_x();
      if (i == 60)       apply(1'b1, 1'b1, int'($urandom_range(0, 2047)));
      else if (i == 130) apply(1'b1, 1'b0, 0);
      else               apply(1'b0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 2047)));
    end

    // Full-scale corners.
    for (int k = 0; k < 4; k++) begin
      nx_r[k] = -1048576;
      nx_i[k] = -1048576;
    end
    apply(1'b0, 1'b1, 2047);
    for (int k = 0; k < 4; k++) begin
      nx_r[k] = 1048575;
      nx_i[k] = -1048576;
    end
    apply(1'b0, 1'b1, 1365);
    zero_x();
    for (int i = 0; i < 7; i++) apply(1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
